if_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipeline, directly upstream of the RAM2 memory controller. It owns the PC, issues instruction-read requests on the controller's IF port, holds the request address stable until the controller reports completion, and loads the IF/ID pipeline register. It also handles hazard stalls and branch redirects without ever corrupting an in-flight RAM2 access.

---
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-read port between the fetch stage and the RAM2 controller
interface if_fetch_unit_if #(
  parameter int ADDR_W = 18
);
  logic              mem_need;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;
  logic [15:0]       mem_data;

  modport master (
    output mem_need,
    output mem_addr,
    input  mem_done,
    input  mem_data
  );

  modport slave (
    input  mem_need,
    input  mem_addr,
    output mem_done,
    output mem_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC, RAM2 IF-port requests, IF/ID register
// Keeps the request address frozen until the controller completes it, so stalls and redirects never retag data.
module if_fetch_unit #(
  parameter int          ADDR_W   = 18,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [15:0]         redirect_pc,
  if_fetch_unit_if.master     mem,
  output logic                id_valid,
  output logic [15:0]         id_inst,
  output logic [15:0]         id_pc,
  output logic [15:0]         id_pc_plus1,
  output logic [15:0]         fetch_cnt
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t            state, state_n;
  logic [15:0]       pc, pc_n;
  logic [15:0]       pc_plus1;
  logic [15:0]       skid_inst, skid_n;
  logic [15:0]       pend_pc, pend_n;
  logic              id_valid_n;
  logic [15:0]       id_inst_n, id_pc_n, id_pc_plus1_n;
  logic [15:0]       cnt_n;
  logic              mem_need_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              done;

  // A completion only counts once our own address is actually on the port.
  assign done         = mem.mem_done & mem_need_q;
  assign pc_plus1     = pc + 16'd1;
  assign mem.mem_need = mem_need_q;
  assign mem.mem_addr = mem_addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      skid_inst   <= NOP_INST;
      pend_pc     <= 16'h0000;
      id_valid    <= 1'b0;
      id_inst     <= NOP_INST;
      id_pc       <= 16'h0000;
      id_pc_plus1 <= 16'h0001;
      fetch_cnt   <= 16'h0000;
      mem_need_q  <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      skid_inst   <= skid_n;
      pend_pc     <= pend_n;
      id_valid    <= id_valid_n;
      id_inst     <= id_inst_n;
      id_pc       <= id_pc_n;
      id_pc_plus1 <= id_pc_plus1_n;
      fetch_cnt   <= cnt_n;
      mem_need_q  <= 1'b1;
      mem_addr_q  <= {{(ADDR_W-16){1'b0}}, pc_n};
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    skid_n        = skid_inst;
    pend_n        = pend_pc;
    id_valid_n    = id_valid;
    id_inst_n     = id_inst;
    id_pc_n       = id_pc;
    id_pc_plus1_n = id_pc_plus1;
    cnt_n         = fetch_cnt;

    case (state)
      FETCH: begin
        if (redirect_valid) begin
          id_valid_n = 1'b0;
          id_inst_n  = NOP_INST;
          // Nothing issued yet, or the issued word just completed: safe to move the address now.
          if (done || !mem_need_q) begin
            pc_n = redirect_pc;
          end else begin
            pend_n  = redirect_pc;
            state_n = FLUSH;
          end
        end else if (done && !stall) begin
          id_valid_n    = 1'b1;
          id_inst_n     = mem.mem_data;
          id_pc_n       = pc;
          id_pc_plus1_n = pc_plus1;
          cnt_n         = fetch_cnt + 16'd1;
          pc_n          = pc_plus1;
        end else if (done) begin
          skid_n  = mem.mem_data;
          state_n = HOLD;
        end else if (!stall) begin
          id_valid_n = 1'b0;
          id_inst_n  = NOP_INST;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          id_valid_n = 1'b0;
          id_inst_n  = NOP_INST;
          pc_n       = redirect_pc;
          state_n    = FETCH;
        end else if (!stall) begin
          id_valid_n    = 1'b1;
          id_inst_n     = skid_inst;
          id_pc_n       = pc;
          id_pc_plus1_n = pc_plus1;
          cnt_n         = fetch_cnt + 16'd1;
          pc_n          = pc_plus1;
          state_n       = FETCH;
        end
      end

      FLUSH: begin
        id_valid_n = 1'b0;
        id_inst_n  = NOP_INST;
        if (redirect_valid) begin
          pend_n = redirect_pc;
          if (done) begin
            pc_n    = redirect_pc;
            state_n = FETCH;
          end
        end else if (done) begin
          pc_n    = pend_pc;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed vector bench for if_fetch_unit with a small RAM2 IF-port model
module tb_if_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        id_valid;
  logic [15:0] id_inst, id_pc, id_pc_plus1, fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit_if #(.ADDR_W(18)) mbus ();

  if_fetch_unit #(.ADDR_W(18), .RESET_PC(16'h0000), .NOP_INST(16'h0800)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem            (mbus.master),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc_plus1    (id_pc_plus1),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Controller model: completes the live address after lat() extra cycles, done tracks the live address.
  logic [15:0] memory [0:65535];
  logic [17:0] last_addr;
  logic        seen;
  logic        done_q;
  int          lat_cnt;

  function automatic int lat(input logic [15:0] a);
    if (a == 16'h0005) return 3;
    if (a == 16'h0100) return 9;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      seen      <= 1'b0;
      done_q    <= 1'b0;
      lat_cnt   <= 0;
      last_addr <= '0;
    end else if (mbus.mem_need) begin
      if (!seen || mbus.mem_addr != last_addr) begin
        last_addr <= mbus.mem_addr;
        seen      <= 1'b1;
        lat_cnt   <= lat(mbus.mem_addr[15:0]);
        done_q    <= (lat(mbus.mem_addr[15:0]) == 0);
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        done_q  <= (lat_cnt == 1);
      end
    end
  end

  assign mbus.mem_done = done_q && seen && (mbus.mem_addr == last_addr);
  assign mbus.mem_data = memory[last_addr[15:0]];

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [15:0] rpc;
    logic        need;
    logic        valid;
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic r, input logic s, input logic rv, input logic [15:0] rpc,
                     input logic need, input logic v, input logic [15:0] inst,
                     input logic [15:0] pc, input logic [15:0] addr, input logic [15:0] cnt);
    vec_t t;
    t = '{r, s, rv, rpc, need, v, inst, pc, addr, cnt};
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int max, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      cycles++;
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int cyc;
    logic [15:0] exp_p1;

    for (int i = 0; i < 65536; i++) memory[i] = 16'h0000;
    memory[16'h0000] = 16'h1111; memory[16'h0001] = 16'h2222;
    memory[16'h0002] = 16'h3333; memory[16'h0003] = 16'h4444;
    memory[16'h0005] = 16'h5555; memory[16'h0010] = 16'hABCD;
    memory[16'h0011] = 16'h5511; memory[16'h0040] = 16'h4040;
    memory[16'h0080] = 16'h8080; memory[16'h0100] = 16'h0101;
    memory[16'hFFFF] = 16'hFFF0;

    // hits from reset: 1111..4444 with bubbles between
    row(0,0,0,16'h0000, 0,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,0,16'h0000, 1,1,16'h1111,16'h0000,16'h0001,16'd1);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0001,16'd1);
    row(1,0,0,16'h0000, 1,1,16'h2222,16'h0001,16'h0002,16'd2);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0001,16'h0002,16'd2);
    row(1,0,0,16'h0000, 1,1,16'h3333,16'h0002,16'h0003,16'd3);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0002,16'h0003,16'd3);
    row(1,0,0,16'h0000, 1,1,16'h4444,16'h0003,16'h0004,16'd4);
    // stall across mem_done at 0x0010, released on the 6th edge
    row(0,0,0,16'h0000, 0,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,1,16'h0010, 1,0,NOP,16'h0000,16'h0010,16'd0);
    for (int i = 0; i < 5; i++) row(1,1,0,16'h0000, 1,0,NOP,16'h0000,16'h0010,16'd0);
    row(1,0,0,16'h0000, 1,1,16'hABCD,16'h0010,16'h0011,16'd1);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0010,16'h0011,16'd1);
    row(1,0,0,16'h0000, 1,1,16'h5511,16'h0011,16'h0012,16'd2);
    // redirect to 0x0040 during a miss at 0x0005
    row(0,0,0,16'h0000, 0,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,1,16'h0005, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,1,16'h0040, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,1,0,16'h0000, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0040,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0040,16'd0);
    row(1,0,0,16'h0000, 1,1,16'h4040,16'h0040,16'h0041,16'd1);
    // two redirects while flushing: latest target wins
    row(0,0,0,16'h0000, 0,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,1,16'h0005, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,1,16'h0040, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,1,16'h0080, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0080,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0080,16'd0);
    row(1,0,0,16'h0000, 1,1,16'h8080,16'h0080,16'h0081,16'd1);
    // redirect coinciding with mem_done, then the 0xFFFF wrap
    row(0,0,0,16'h0000, 0,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,1,16'hFFFF, 1,0,NOP,16'h0000,16'hFFFF,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'hFFFF,16'd0);
    row(1,0,0,16'h0000, 1,1,16'hFFF0,16'hFFFF,16'h0000,16'd1);
    row(1,0,0,16'h0000, 1,0,NOP,16'hFFFF,16'h0000,16'd1);
    row(1,0,0,16'h0000, 1,1,16'h1111,16'h0000,16'h0001,16'd2);
    // reset in the middle of a miss
    row(0,0,0,16'h0000, 0,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,1,16'h0005, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0005,16'd0);
    row(0,0,0,16'h0000, 0,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,0,16'h0000, 1,0,NOP,16'h0000,16'h0000,16'd0);
    row(1,0,0,16'h0000, 1,1,16'h1111,16'h0000,16'h0001,16'd1);

    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      stall          = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      tick();
      exp_p1 = vecs[i].pc + 16'd1;
      cmp("mem_need",    i, {31'd0, mbus.mem_need}, {31'd0, vecs[i].need});
      cmp("mem_addr",    i, {14'd0, mbus.mem_addr}, {16'd0, vecs[i].addr});
      cmp("id_valid",    i, {31'd0, id_valid},      {31'd0, vecs[i].valid});
      cmp("id_inst",     i, {16'd0, id_inst},       {16'd0, vecs[i].inst});
      cmp("id_pc",       i, {16'd0, id_pc},         {16'd0, vecs[i].pc});
      cmp("id_pc_plus1", i, {16'd0, id_pc_plus1},   {16'd0, exp_p1});
      cmp("fetch_cnt",   i, {16'd0, fetch_cnt},     {16'd0, vecs[i].cnt});
    end

    // redirect while parked in HOLD under stall: skid dropped, target fetched
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0; stall = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0080;
    tick();
    cmp("hold_redir_addr",  0, {14'd0, mbus.mem_addr}, 32'h0000_0080);
    cmp("hold_redir_valid", 0, {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b0; stall = 1'b0;
    wait_valid(10, ok, cyc);
    cmp("hold_redir_timeout", 0, {31'd0, ok}, 32'd1);
    cmp("hold_redir_inst",    0, {16'd0, id_inst}, 32'h0000_8080);
    cmp("hold_redir_pc",      0, {16'd0, id_pc}, 32'h0000_0080);
    cmp("hold_redir_cnt",     0, {16'd0, fetch_cnt}, 32'd1);

    // long controller delay: address presented at E1, latched E2, done after E11, loaded E12
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    wait_valid(30, ok, cyc);
    cmp("slow_timeout", 0, {31'd0, ok}, 32'd1);
    cmp("slow_cycles",  0, cyc, 32'd11);
    cmp("slow_inst",    0, {16'd0, id_inst}, 32'h0000_0101);
    cmp("slow_pc",      0, {16'd0, id_pc}, 32'h0000_0100);
    cmp("slow_addr",    0, {14'd0, mbus.mem_addr}, 32'h0000_0101);

    // fetch_cnt wrap: preload 0xFFFE between edges, then two deliveries
    do_reset();
    tick();
    tick();
    force dut.fetch_cnt = 16'hFFFE;
    #1;
    release dut.fetch_cnt;
    tick();
    cmp("wrap_cnt_ffff", 0, {16'd0, fetch_cnt}, 32'h0000_FFFF);
    cmp("wrap_inst0",    0, {16'd0, id_inst}, 32'h0000_1111);
    tick();
    tick();
    cmp("wrap_cnt_0000", 0, {16'd0, fetch_cnt}, 32'h0000_0000);
    cmp("wrap_inst1",    0, {16'd0, id_inst}, 32'h0000_2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
